dice_result_tracker: RTL and testbench
======================================

// Module: dice_result_tracker
// PURPOSE
//  Downstream consumer of the dice roller. Watches the roll button and the roller's throw[2:0].
//  After the button is released and throw has settled, captures one result and presents it on a
//  valid/ready interface. Keeps roll statistics: count, running total and repeat ("double") detect.
// PARAMETERS
//  SETTLE_CYC  2   cycles to wait after button falls before sampling throw (1..15)
//  TOT_W       16  width of running total (saturating)
//  CNT_W       8   width of each per-face histogram counter (DICE_HISTOGRAM_EN only)
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset: asynchronous, active-high
//  button      in   1      roll button, synchronous to clk (same signal as roller input)
//  throw       in   3      roller output; legal faces 1..6
//  res_ready   in   1      consumer accepts result
//  res_valid   out  1      result available
//  res_value   out  3      captured face 1..6
//  res_double  out  1      res_value equals the previous accepted result
//  roll_count  out  16     number of accepted results, wraps 0xFFFF->0
//  total       out  TOT_W  sum of accepted results, saturates at all-ones
//  err_invalid out  1      1-cycle pulse: throw was 0 or 7 at sample time
//  hist_sel    in   3      face select 1..6 (DICE_HISTOGRAM_EN only)
//  hist_count  out  CNT_W  accepted count for hist_sel; 0 for sel 0/7 (DICE_HISTOGRAM_EN only)
// BEHAVIOUR
//  Reset: state IDLE; res_valid=0, res_value=0, res_double=0, roll_count=0, total=0,
//   err_invalid=0, prev-result register empty, histogram counters 0. Reset mid-roll or
//   mid-present aborts immediately; the pending result is lost.
//  button_q = button registered once; fall = button_q & ~button.
//  FSM:
//   IDLE    : button=1 -> ROLLING.
//   ROLLING : fall -> SETTLE; settle counter loads SETTLE_CYC-1.
//   SETTLE  : counter decrements each cycle. button=1 -> back to ROLLING (no capture).
//             At counter==0, sample throw:
//               legal (1..6) -> res_value=throw, res_valid=1, state PRESENT;
//               illegal      -> err_invalid=1 for one cycle, state IDLE.
//   PRESENT : res_valid held, res_value/res_double stable until res_valid&res_ready.
//             Button ignored here. On handshake: res_valid=0 next cycle, stats update;
//             next state = ROLLING if button=1, else IDLE.
//  Capture latency: res_valid rises SETTLE_CYC+1 cycles after the cycle where button falls.
//  res_double computed at capture: 1 iff prev-result register holds a value equal to throw.
//   Always 0 for the first result after reset.
//  Stats update on handshake only: roll_count+1 (wrap), total+res_value (saturate),
//   prev-result <= res_value.
//  res_ready high while res_valid=0 has no effect.
//  Handshake in the first PRESENT cycle is legal: single-cycle res_valid.
// CONFIGURATION
//  DICE_HISTOGRAM_EN defined: six CNT_W counters, one per face. Each increments on handshake
//   for its face and saturates at all-ones. hist_sel/hist_count ports exist; read is combinational.
//  Not defined: no counters and no hist_sel/hist_count ports; all other behaviour is identical.
// STRUCTURE
//  dice_pkg holds:
//   - state enum {IDLE, ROLLING, SETTLE, PRESENT}
//   - FACE_MIN=3'd1, FACE_MAX=3'd6
//   - function is_legal_face(logic [2:0])
//  Sub-module dice_face_hist holds the six counters and the read mux. It is instantiated only
//   under DICE_HISTOGRAM_EN.
// TESTING
//  1 reset; button high 5 cyc, low; throw=4, ready=1 -> valid 3 cyc after fall, value=4,
//    roll_count=1, total=4, double=0
//  2 roll 3, accept; roll 3 again -> res_double=1; roll 5 -> res_double=0; total=11
//  3 throw=0 at sample -> err_invalid 1-cycle pulse, no res_valid, roll_count unchanged
//  4 button re-pressed during SETTLE -> no capture; after final release, exactly one result
//  5 ready=0 for 10 cyc while button toggles -> value held stable; accept; button=1 -> ROLLING
//  6 assert rst during PRESENT -> res_valid=0 at once, all stats 0; with DICE_HISTOGRAM_EN,
//    300 accepted 6s -> hist_count(sel=6)=255 (saturated), hist_count(sel=0)=0

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types and face helpers for the dice result tracker.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLLING,
    SETTLE,
    PRESENT
  } state_t;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;

  localparam int unsigned ROLL_CNT_W   = 16;
  localparam int unsigned SETTLE_CNT_W = 4;
  localparam int unsigned FACE_NUM     = 6;

  // A face is usable only in the range 1..6; 0 and 7 mean the roller glitched.
  function automatic logic is_legal_face(input logic [2:0] face);
    return (face >= FACE_MIN) && (face <= FACE_MAX);
  endfunction

endpackage

// File: rtl/dice_result_tracker_if.sv
// Valid/ready result channel from the tracker to its consumer.
interface dice_result_tracker_if;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_value;
  logic       res_double;

  modport master (output res_valid, output res_value, output res_double, input res_ready);
  modport slave  (input res_valid, input res_value, input res_double, output res_ready);
endinterface

// File: rtl/dice_face_hist.sv
// Per-face accepted-result counters (saturating) with a combinational read mux.
module dice_face_hist
  import dice_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [2:0]       face,
  input  logic [2:0]       hist_sel,
  output logic [CNT_W-1:0] hist_count
);

  logic [CNT_W-1:0] cnt [FACE_NUM];

  // Bump the counter of the accepted face, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FACE_NUM; i++) cnt[i] <= '0;
    end else if (inc) begin
      for (int i = 0; i < FACE_NUM; i++) begin
        if ((face == 3'(i + 1)) && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Select 1..6 reads a counter; 0 and 7 read zero.
  always_comb begin
    hist_count = '0;
    for (int i = 0; i < FACE_NUM; i++) begin
      if (hist_sel == 3'(i + 1)) hist_count = cnt[i];
    end
  end

endmodule

// File: rtl/dice_result_tracker.sv
// Captures one settled dice result per roll, presents it on valid/ready and keeps stats.
// Optional per-face histogram: define DICE_HISTOGRAM_EN.
module dice_result_tracker
  import dice_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned TOT_W      = 16
`ifdef DICE_HISTOGRAM_EN
  , parameter int unsigned CNT_W    = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   button,
  input  logic [2:0]             throw,
  dice_result_tracker_if.master  res,
  output logic [ROLL_CNT_W-1:0]  roll_count,
  output logic [TOT_W-1:0]       total,
  output logic                   err_invalid
`ifdef DICE_HISTOGRAM_EN
  , input  logic [2:0]           hist_sel
  , output logic [CNT_W-1:0]     hist_count
`endif
);

  localparam int unsigned SUM_W = TOT_W + 1;
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYC - 1);

  state_t                  state;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic                    button_q;
  logic                    valid_q;
  logic [2:0]              value_q;
  logic                    double_q;
  logic                    prev_vld;
  logic [2:0]              prev_val;
  logic                    fall_c;
  logic                    hs_c;
  logic [SUM_W-1:0]        sum_c;

  assign fall_c = button_q & ~button;
  assign hs_c   = valid_q & res.res_ready;
  assign sum_c  = {1'b0, total} + SUM_W'(value_q);

  assign res.res_valid  = valid_q;
  assign res.res_value  = value_q;
  assign res.res_double = double_q;

  // Button history for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) button_q <= 1'b0;
    else     button_q <= button;
  end

  // Roll sequencing: wait for release, let throw settle, then capture or flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      valid_q     <= 1'b0;
      value_q     <= '0;
      double_q    <= 1'b0;
      err_invalid <= 1'b0;
    end else begin
      err_invalid <= 1'b0;
      case (state)
        IDLE: begin
          if (button) state <= ROLLING;
        end
        ROLLING: begin
          if (fall_c) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (button) begin
            state <= ROLLING;
          end else if (settle_cnt == '0) begin
            if (is_legal_face(throw)) begin
              value_q  <= throw;
              double_q <= prev_vld && (prev_val == throw);
              valid_q  <= 1'b1;
              state    <= PRESENT;
            end else begin
              err_invalid <= 1'b1;
              state       <= IDLE;
            end
          end else begin
            settle_cnt <= settle_cnt - SETTLE_CNT_W'(1);
          end
        end
        PRESENT: begin
          if (hs_c) begin
            valid_q <= 1'b0;
            state   <= button ? ROLLING : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics advance only when the consumer takes a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      roll_count <= '0;
      total      <= '0;
      prev_vld   <= 1'b0;
      prev_val   <= '0;
    end else if (hs_c) begin
      roll_count <= roll_count + ROLL_CNT_W'(1);
      total      <= sum_c[TOT_W] ? '1 : sum_c[TOT_W-1:0];
      prev_vld   <= 1'b1;
      prev_val   <= value_q;
    end
  end

`ifdef DICE_HISTOGRAM_EN
  dice_face_hist #(
    .CNT_W (CNT_W)
  ) u_hist (
    .clk        (clk),
    .rst        (rst),
    .inc        (hs_c),
    .face       (value_q),
    .hist_sel   (hist_sel),
    .hist_count (hist_count)
  );
`endif

endmodule

// File: tb/tb_dice_result_tracker.sv
// Directed bench for dice_result_tracker (SETTLE_CYC=2, TOT_W=16).
module tb_dice_result_tracker;
  import dice_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        button;
  logic [2:0]  throw;
  logic [15:0] roll_count;
  logic [15:0] total;
  logic        err_invalid;
`ifdef DICE_HISTOGRAM_EN
  logic [2:0]  hist_sel;
  logic [7:0]  hist_count;
`endif

  int checks = 0;
  int passed = 0;

  dice_result_tracker_if rif ();

  dice_result_tracker #(
    .SETTLE_CYC (2),
    .TOT_W      (16)
`ifdef DICE_HISTOGRAM_EN
    , .CNT_W    (8)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .button      (button),
    .throw       (throw),
    .res         (rif),
    .roll_count  (roll_count),
    .total       (total),
    .err_invalid (err_invalid)
`ifdef DICE_HISTOGRAM_EN
    , .hist_sel   (hist_sel)
    , .hist_count (hist_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Press, release, accept immediately (ready already high); checks latency, value and stats.
  task automatic roll_accept(input string tag, input logic [2:0] face, input int exp_dbl,
                             input int exp_cnt, input int exp_tot);
    button = 1'b1;
    throw  = face;
    step(2);
    button = 1'b0;
    step(2);
    check({tag, "_early"}, 32'(rif.res_valid), 0);
    step(1);
    check({tag, "_valid"}, 32'(rif.res_valid), 1);
    check({tag, "_value"}, 32'(rif.res_value), 32'(face));
    check({tag, "_double"}, 32'(rif.res_double), exp_dbl);
    step(1);
    check({tag, "_drop"}, 32'(rif.res_valid), 0);
    check({tag, "_count"}, 32'(roll_count), exp_cnt);
    check({tag, "_total"}, 32'(total), exp_tot);
  endtask

  initial begin
    rst = 1'b1;
    button = 1'b0;
    throw = 3'd0;
    rif.res_ready = 1'b0;
`ifdef DICE_HISTOGRAM_EN
    hist_sel = 3'd0;
`endif
    step(2);
    check("rst_valid", 32'(rif.res_valid), 0);
    check("rst_value", 32'(rif.res_value), 0);
    check("rst_double", 32'(rif.res_double), 0);
    check("rst_count", 32'(roll_count), 0);
    check("rst_total", 32'(total), 0);
    check("rst_err", 32'(err_invalid), 0);
    rst = 1'b0;
    step(1);

    // 1: long press, throw 4, ready high.
    rif.res_ready = 1'b1;
    button = 1'b1;
    throw = 3'd4;
    step(5);
    button = 1'b0;
    step(2);
    check("t1_early", 32'(rif.res_valid), 0);
    step(1);
    check("t1_valid", 32'(rif.res_valid), 1);
    check("t1_value", 32'(rif.res_value), 4);
    check("t1_double", 32'(rif.res_double), 0);
    check("t1_cnt_pre", 32'(roll_count), 0);
    step(1);
    check("t1_drop", 32'(rif.res_valid), 0);
    check("t1_count", 32'(roll_count), 1);
    check("t1_total", 32'(total), 4);

    // 2: fresh stats; 3, 3 (double), 5.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    roll_accept("t2a", 3'd3, 0, 1, 3);
    roll_accept("t2b", 3'd3, 1, 2, 6);
    roll_accept("t2c", 3'd5, 0, 3, 11);

    // 3: illegal face at sample time.
    button = 1'b1;
    throw = 3'd0;
    step(2);
    button = 1'b0;
    step(2);
    check("t3_err_early", 32'(err_invalid), 0);
    step(1);
    check("t3_err", 32'(err_invalid), 1);
    check("t3_valid", 32'(rif.res_valid), 0);
    step(1);
    check("t3_err_pulse", 32'(err_invalid), 0);
    check("t3_valid2", 32'(rif.res_valid), 0);
    check("t3_count", 32'(roll_count), 3);

    // 4: re-press during settle, then one clean release.
    button = 1'b1;
    throw = 3'd2;
    step(2);
    button = 1'b0;
    step(1);
    button = 1'b1;
    step(3);
    check("t4_nocap", 32'(rif.res_valid), 0);
    button = 1'b0;
    step(2);
    check("t4_early", 32'(rif.res_valid), 0);
    step(1);
    check("t4_valid", 32'(rif.res_valid), 1);
    check("t4_value", 32'(rif.res_value), 2);
    check("t4_double", 32'(rif.res_double), 0);
    step(1);
    check("t4_count", 32'(roll_count), 4);
    check("t4_total", 32'(total), 13);
    step(5);
    check("t4_single", 32'(rif.res_valid), 0);
    check("t4_count2", 32'(roll_count), 4);

    // 5: consumer stalls while button and throw wander.
    rif.res_ready = 1'b0;
    button = 1'b1;
    throw = 3'd6;
    step(2);
    button = 1'b0;
    step(3);
    check("t5_valid", 32'(rif.res_valid), 1);
    for (int i = 0; i < 10; i++) begin
      button = i[0];
      throw = 3'(i);
      step(1);
      check("t5_hold_valid", 32'(rif.res_valid), 1);
      check("t5_hold_value", 32'(rif.res_value), 6);
    end
    check("t5_cnt_stall", 32'(roll_count), 4);
    button = 1'b1;
    rif.res_ready = 1'b1;
    step(1);
    check("t5_drop", 32'(rif.res_valid), 0);
    check("t5_count", 32'(roll_count), 5);
    check("t5_total", 32'(total), 19);
    // Release right away: only a ROLLING state sees this as a fall.
    button = 1'b0;
    throw = 3'd1;
    step(3);
    check("t5_rolling", 32'(rif.res_valid), 1);
    check("t5_value2", 32'(rif.res_value), 1);
    step(1);
    check("t5_count2", 32'(roll_count), 6);
    check("t5_total2", 32'(total), 20);

    // 6: asynchronous reset while a result is pending.
    rif.res_ready = 1'b0;
    button = 1'b1;
    throw = 3'd2;
    step(2);
    button = 1'b0;
    step(3);
    check("t6_pending", 32'(rif.res_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(rif.res_valid), 0);
    check("t6_async_count", 32'(roll_count), 0);
    check("t6_async_total", 32'(total), 0);
    step(1);
    rst = 1'b0;
    rif.res_ready = 1'b1;
    step(1);
    check("t6_value", 32'(rif.res_value), 0);
    // Previous result (1) must have been forgotten.
    roll_accept("t6_first", 3'd1, 0, 1, 1);

`ifdef DICE_HISTOGRAM_EN
    for (int i = 0; i < 300; i++) begin
      button = 1'b1;
      throw = 3'd6;
      step(1);
      button = 1'b0;
      step(4);
    end
    check("h_count", 32'(roll_count), 301);
    check("h_total", 32'(total), 1801);
    hist_sel = 3'd6;
    #1;
    check("h_sel6", 32'(hist_count), 255);
    hist_sel = 3'd1;
    #1;
    check("h_sel1", 32'(hist_count), 1);
    hist_sel = 3'd0;
    #1;
    check("h_sel0", 32'(hist_count), 0);
    hist_sel = 3'd7;
    #1;
    check("h_sel7", 32'(hist_count), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
